// File: rtl/pipelined_adder_pkg.sv
// pipelined_adder_pkg: default sizing and chunk helpers shared by the pipelined adder
package pipelined_adder_pkg;
  localparam int DEF_WIDTH  = 16;
  localparam int DEF_STAGES = 4;
  function automatic int chunk_w(input int w, input int n);
    return w / n;
  endfunction
  function automatic bit cfg_ok(input int w, input int n);
    return (n >= 1) && (n <= w) && (w % n == 0);
  endfunction
endpackage

// File: rtl/pipelined_adder_adder_chunk.sv
// adder_chunk: combinational ripple adder for one pipeline chunk
module adder_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         ci,
  output logic [W-1:0] sum,
  output logic         co
);
  logic c;
  always_comb begin
    c = ci;
    sum = '0;
    for (int i = 0; i < W; i++) begin
      sum[i] = x[i] ^ y[i] ^ c;
      c = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    co = c;
  end
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: STAGES-deep chunked add/subtract with valid/ready whole-pipeline stall
// PIPELINED_ADDER_OVF_EN adds a registered two's-complement overflow output ovf
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
`ifdef PIPELINED_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             c_out
);
  localparam int C = chunk_w(WIDTH, STAGES);
  if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg
    $error("pipelined_adder: WIDTH must be a multiple of STAGES, STAGES in 1..WIDTH");
  end
  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign b_eff    = sub ? ~b : b;
  assign cin_eff  = sub || c_in;
  for (genvar k = 0; k < STAGES; k++) begin : st
    logic [C-1:0]       x, y, sum;
    logic               ci, co, vi;
    logic [(k+1)*C-1:0] nps, ps;
    logic               pc, pv;
    if (k == 0) begin : g_src
      assign x   = a[C-1:0];
      assign y   = b_eff[C-1:0];
      assign ci  = cin_eff;
      assign vi  = in_valid;
      assign nps = sum;
    end else begin : g_src
      assign x   = st[k-1].g_sk.ra[C-1:0];
      assign y   = st[k-1].g_sk.rb[C-1:0];
      assign ci  = st[k-1].pc;
      assign vi  = st[k-1].pv;
      assign nps = {sum, st[k-1].ps};
    end
    adder_chunk #(.W(C)) u_add (.x(x), .y(y), .ci(ci), .sum(sum), .co(co));
    // last stage only loads on a valid result so s/c_out hold across bubbles
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        ps <= '0;
        pc <= 1'b0;
        pv <= 1'b0;
      end else if (adv) begin
        pv <= vi;
        if (k < STAGES - 1 || vi) begin
          ps <= nps;
          pc <= co;
        end
      end
    if (k < STAGES - 1) begin : g_sk
      localparam int R = (STAGES - 1 - k) * C;
      logic [R-1:0] ra, rb, na, nb;
      if (k == 0) begin : g_in
        assign na = a[WIDTH-1:C];
        assign nb = b_eff[WIDTH-1:C];
      end else begin : g_in
        assign na = st[k-1].g_sk.ra[R+C-1:C];
        assign nb = st[k-1].g_sk.rb[R+C-1:C];
      end
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          ra <= '0;
          rb <= '0;
        end else if (adv) begin
          ra <= na;
          rb <= nb;
        end
    end
  end
`ifdef PIPELINED_ADDER_OVF_EN
  // carry into the MSB is recovered from the MSB sum bit of the final chunk
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf <= 1'b0;
    else if (adv && st[STAGES-1].vi)
      ovf <= st[STAGES-1].x[C-1] ^ st[STAGES-1].y[C-1] ^ st[STAGES-1].sum[C-1] ^ st[STAGES-1].co;
`endif
  assign s         = st[STAGES-1].ps;
  assign c_out     = st[STAGES-1].pc;
  assign out_valid = st[STAGES-1].pv;
endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised N-bit add/subtract unit; successor to the single-bit full adder.
- Splits the operands into STAGES equal chunks and resolves one chunk per clock, with carry registered between stages.
- Valid/ready handshake on input and output, with whole-pipeline stall.
- Sits in the datapath library as the standard registered adder for accumulators and address generators.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages (1..WIDTH); chunk width CHUNK = WIDTH/STAGES.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  unit accepts operands this cycle.
- a  input  WIDTH  addend / minuend.
- b  input  WIDTH  addend / subtrahend.
- c_in  input  1  carry in (ignored when sub=1).
- sub  input  1  0: a+b+c_in; 1: a-b (a + ~b + 1).
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts result.
- s  output  WIDTH  sum / difference.
- c_out  output  1  carry out of MSB (for sub: 1 = no borrow).

Behaviour:
- Reset (async, rst_n=0): all stage valid bits, carry registers, skew/deskew registers, s, c_out and out_valid go to 0 immediately. in_ready is 1 after reset.
- Reset mid-operation discards all in-flight results; no partial output is ever emitted.
- Advance enable: adv = !out_valid || out_ready. in_ready = adv (combinational).
- Transfers:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Stage 0 behaviour on adv:
  - Captures chunk 0 of a and b_eff (b_eff = sub ? ~b : b) with cin_eff = sub ? 1 : c_in.
  - Registers the CHUNK-bit sum and carry.
  - Registers chunks 1..STAGES-1 of a and b_eff into skew registers.
- Stage k (k≥1) behaviour on adv:
  - Adds the skewed chunk k plus stage k-1's registered carry.
  - Forwards the lower sum chunks through deskew registers.
- Stage valid bits shift on adv. Stage 0 valid loads in_valid. When adv=0, every register holds.
- Latency: exactly STAGES cycles from input transfer to out_valid, with no stalls. Throughput is one result per cycle when out_ready=1.
- Holding requirements:
  - out_valid=1 && out_ready=0: s, c_out, out_valid hold stable and in_ready=0.
  - out_valid=1 && out_ready=1 with in_valid=1: the result leaves and a new operand enters in the same cycle (no bubble).
- Arithmetic:
  - Result is modulo 2^WIDTH; c_out is the true carry of the WIDTH-bit addition.
  - Bubbles (in_valid=0 on adv) propagate as invalid stages; s holds its last value when out_valid=0.
- STAGES=1 degenerates to a single registered adder: latency 1, no skew/deskew registers.

Optional Feature:
- Macro: PIPELINED_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), registered and aligned with s.
  - ovf is the two's-complement overflow: carry into MSB XOR carry out of MSB of the final stage.
  - Reset value 0; holds with s during stall.
- Undefined: port absent, no extra logic.

Decomposition:
- Shared header/package holds:
  - Default WIDTH/STAGES constants.
  - CHUNK derivation.
  - An elaboration-time check that WIDTH % STAGES == 0 (error otherwise).
- One sub-module: adder_chunk.
  - Combinational CHUNK-bit ripple adder built from per-bit sum/carry equations.
  - Ports: x, y, ci, sum, co.
  - Instantiated once per stage via generate.
- Pipeline registers, handshake and deskew live in pipelined_adder.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, s=0, c_out=0. Deassert, then send a=0x1234, b=0x1111, sub=0, c_in=0 -> after 4 cycles out_valid=1, s=0x2345, c_out=0.
- Carry chain across all stages: a=0xFFFF, b=0x0000, c_in=1 -> s=0x0000, c_out=1 at cycle 4; with OVF_EN, ovf=0.
- Subtract:
  - a=0x0005, b=0x0007, sub=1 -> s=0xFFFE, c_out=0.
  - a=0x0007, b=0x0005 -> s=0x0002, c_out=1.
  - With OVF_EN, a=0x8000, b=0x0001, sub=1 -> s=0x7FFF, ovf=1.
- Back-to-back stream: 8 consecutive inputs (a=i, b=0x0100*i) with out_ready=1 -> 8 consecutive out_valid cycles, in order, correct sums, in_ready never drops.
- Backpressure: stream 6 inputs, drop out_ready for 3 cycles while results are pending -> s stable and in_ready=0 during the stall; no result lost or duplicated; order preserved.
- Reset mid-flight: assert rst_n=0 with 3 operations in flight -> out_valid=0 immediately. After release, no stale result appears within 4 cycles without new input.
